// File: rtl/mixer_pkg.sv
// Shared types and default sizing for the mixer LO sequencer.
package mixer_pkg;

  localparam int DEF_DIV_W    = 8;
  localparam int DEF_DWELL_W  = 12;
  localparam int DEF_DEAD_CYC = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INT     = 2'd1,
    HANDOFF = 2'd2,
    EXT     = 2'd3
  } lo_state_t;

endpackage

// File: rtl/mixer_lo_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous external LO pad inputs.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mixer_lo_sequencer.sv
// Non-overlapping differential LO generator with ratio sweep and glitch-free
// handover to a synchronized external LO.
//
// state   | meaning
// IDLE    | outputs 0/0, waiting for run or external select
// INT     | internal LO running from cur_div
// HANDOFF | both outputs low for DEAD_CYC cycles before external pass-through
// EXT     | synchronized external LO passed through, overlap forced to 0/0
module mixer_lo_sequencer
  import mixer_pkg::*;
#(
  parameter int DIV_W    = DEF_DIV_W,
  parameter int DWELL_W  = DEF_DWELL_W,
  parameter int DEAD_CYC = DEF_DEAD_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               sweep_en,
  input  logic [DIV_W-1:0]   div_start,
  input  logic [DIV_W-1:0]   div_stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               ext_lo_en,
  input  logic               ext_lo_p,
  input  logic               ext_lo_n,
  output logic               lo_p,
  output logic               lo_n,
  output logic [DIV_W-1:0]   cur_div,
  output logic               busy,
  output logic               wrap
);

  localparam logic [DIV_W-1:0] DEAD_V  = DIV_W'(DEAD_CYC);
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(DEAD_CYC + 1);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  logic ext_lo_en_s, ext_lo_p_s, ext_lo_n_s;

  sync2 u_sync_en (.clk(clk), .rst(rst), .d(ext_lo_en), .q(ext_lo_en_s));
  sync2 u_sync_p  (.clk(clk), .rst(rst), .d(ext_lo_p),  .q(ext_lo_p_s));
  sync2 u_sync_n  (.clk(clk), .rst(rst), .d(ext_lo_n),  .q(ext_lo_n_s));

  lo_state_t          state, state_nxt;
  logic [DIV_W-1:0]   cnt, cnt_nxt;
  logic               phase, phase_nxt;
  logic [DIV_W-1:0]   cur_div_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
  logic               lo_p_nxt, lo_n_nxt, wrap_nxt;
  logic               load_int;

  logic [DIV_W-1:0]   start_c, stop_c;
  logic               sweep_up, sweep_dn, at_stop;
  logic               half_end, boundary;

  assign start_c  = clamp_div(div_start);
  assign stop_c   = clamp_div(div_stop);
  assign sweep_up = (stop_c > start_c);
  assign sweep_dn = (stop_c < start_c);
  // Overshoot (cur_div already past stop) is treated as reaching it.
  assign at_stop  = sweep_up ? (cur_div >= stop_c) :
                    sweep_dn ? (cur_div <= stop_c) : 1'b1;
  assign half_end = (cnt == cur_div - 1'b1);
  assign boundary = half_end && phase;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    phase_nxt   = phase;
    cur_div_nxt = cur_div;
    dwell_nxt   = dwell_cnt;
    wrap_nxt    = 1'b0;
    load_int    = 1'b0;
    lo_p_nxt    = 1'b0;
    lo_n_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (ext_lo_en_s) begin
          state_nxt = EXT;
        end else if (run) begin
          load_int = 1'b1;
        end
      end

      INT: begin
        if (half_end) begin
          cnt_nxt   = '0;
          phase_nxt = ~phase;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
        if (!sweep_en) begin
          dwell_nxt = '0;
        end
        if (boundary) begin
          if (ext_lo_en_s) begin
            state_nxt = HANDOFF;
            phase_nxt = 1'b0;
          end else if (!run) begin
            state_nxt = IDLE;
            phase_nxt = 1'b0;
          end else if (sweep_en) begin
            if (dwell_cnt == dwell) begin
              dwell_nxt = '0;
              if (sweep_up || sweep_dn) begin
                if (at_stop) begin
                  cur_div_nxt = start_c;
                  wrap_nxt    = 1'b1;
                end else if (sweep_up) begin
                  cur_div_nxt = cur_div + 1'b1;
                end else begin
                  cur_div_nxt = cur_div - 1'b1;
                end
              end
            end else begin
              dwell_nxt = dwell_cnt + 1'b1;
            end
          end
        end
      end

      HANDOFF: begin
        if (cnt == DEAD_V - 1'b1) begin
          state_nxt = EXT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      EXT: begin
        if (!ext_lo_en_s) begin
          if (run) begin
            load_int = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Fresh INT start: counter 0 in phase P gives the leading dead window.
    if (load_int) begin
      state_nxt   = INT;
      cur_div_nxt = start_c;
      dwell_nxt   = '0;
      cnt_nxt     = '0;
      phase_nxt   = 1'b0;
    end

    case (state_nxt)
      INT: begin
        if (cnt_nxt >= DEAD_V) begin
          lo_p_nxt = ~phase_nxt;
          lo_n_nxt = phase_nxt;
        end
      end
      EXT: begin
        lo_p_nxt = ext_lo_p_s & ~ext_lo_n_s;
        lo_n_nxt = ext_lo_n_s & ~ext_lo_p_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= 1'b0;
      cur_div   <= '0;
      dwell_cnt <= '0;
      lo_p      <= 1'b0;
      lo_n      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      phase     <= phase_nxt;
      cur_div   <= cur_div_nxt;
      dwell_cnt <= dwell_nxt;
      lo_p      <= lo_p_nxt;
      lo_n      <= lo_n_nxt;
      wrap      <= wrap_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mixer_lo_sequencer.sv
// Scoreboard bench: stimulus queues hand-derived per-cycle output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_mixer_lo_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        sweep_en = 1'b0;
  logic [7:0]  div_start = 8'd0;
  logic [7:0]  div_stop = 8'd0;
  logic [11:0] dwell = 12'd0;
  logic        ext_lo_en = 1'b0;
  logic        ext_lo_p = 1'b0;
  logic        ext_lo_n = 1'b0;
  logic        lo_p, lo_n, busy, wrap;
  logic [7:0]  cur_div;

  typedef struct {
    logic       p;
    logic       n;
    logic [7:0] cd;
    logic       busy;
    logic       wrap;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  mixer_lo_sequencer #(.DIV_W(8), .DWELL_W(12), .DEAD_CYC(1)) dut (
    .clk(clk), .rst(rst), .run(run), .sweep_en(sweep_en),
    .div_start(div_start), .div_stop(div_stop), .dwell(dwell),
    .ext_lo_en(ext_lo_en), .ext_lo_p(ext_lo_p), .ext_lo_n(ext_lo_n),
    .lo_p(lo_p), .lo_n(lo_n), .cur_div(cur_div), .busy(busy), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({lo_p, lo_n, cur_div, busy, wrap} !== {e.p, e.n, e.cd, e.busy, e.wrap}) begin
        errors++;
        $display("FAIL %s: got p=%0b n=%0b div=%0d busy=%0b wrap=%0b, want p=%0b n=%0b div=%0d busy=%0b wrap=%0b",
                 e.tag, lo_p, lo_n, cur_div, busy, wrap, e.p, e.n, e.cd, e.busy, e.wrap);
      end
    end
  end

  task automatic push_e(input logic p, input logic n, input int cd,
                        input logic b, input logic w, input string tag);
    exp_t e;
    e.p = p; e.n = n; e.cd = 8'(cd); e.busy = b; e.wrap = w; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // One LO period at ratio r with a single dead cycle per half.
  task automatic push_period(input int r, input int cd, input logic w_first, input string tag);
    push_e(1'b0, 1'b0, cd, 1'b1, w_first, tag);
    for (int i = 1; i < r; i++) push_e(1'b1, 1'b0, cd, 1'b1, 1'b0, tag);
    push_e(1'b0, 1'b0, cd, 1'b1, 1'b0, tag);
    for (int i = 1; i < r; i++) push_e(1'b0, 1'b1, cd, 1'b1, 1'b0, tag);
  endtask

  task automatic push_idle(input int n, input int cd, input string tag);
    for (int i = 0; i < n; i++) push_e(1'b0, 1'b0, cd, 1'b0, 1'b0, tag);
  endtask

  task automatic push_n(input int n, input logic p, input logic q, input int cd, input string tag);
    for (int i = 0; i < n; i++) push_e(p, q, cd, 1'b1, 1'b0, tag);
  endtask

  task automatic drain(input int max_cyc);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < max_cyc) begin
      @(posedge clk);
      c++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected vectors left after %0d cycles, want 0", exp_q.size(), max_cyc);
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    push_idle(3, 0, "reset_idle");
    rst = 1'b0;
    drain(10);

    // Fixed divide 4, then run dropped mid third period
    div_start = 8'd4; sweep_en = 1'b0;
    @(negedge clk); #1;
    for (int p = 0; p < 3; p++) push_period(4, 4, 1'b0, "fixed_div4");
    push_idle(3, 4, "run_drop_idle");
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (i == 19) run = 1'b0;
    end
    drain(40);

    // Up sweep 3..5, dwell 1
    div_start = 8'd3; div_stop = 8'd5; dwell = 12'd1; sweep_en = 1'b1;
    @(negedge clk); #1;
    push_period(3, 3, 1'b0, "up_3a"); push_period(3, 3, 1'b0, "up_3b");
    push_period(4, 4, 1'b0, "up_4a"); push_period(4, 4, 1'b0, "up_4b");
    push_period(5, 5, 1'b0, "up_5a"); push_period(5, 5, 1'b0, "up_5b");
    push_period(3, 3, 1'b1, "up_wrap"); push_period(3, 3, 1'b0, "up_3c");
    push_idle(3, 3, "up_idle");
    run = 1'b1;
    for (int i = 0; i < 56; i++) begin
      @(posedge clk); #2;
      if (i == 55) run = 1'b0;
    end
    drain(80);

    // Down sweep 5..0 clamps at 2, dwell 0
    div_start = 8'd5; div_stop = 8'd0; dwell = 12'd0; sweep_en = 1'b1;
    @(negedge clk); #1;
    push_period(5, 5, 1'b0, "dn_5"); push_period(4, 4, 1'b0, "dn_4");
    push_period(3, 3, 1'b0, "dn_3"); push_period(2, 2, 1'b0, "dn_clamp2");
    push_period(5, 5, 1'b1, "dn_wrap"); push_period(4, 4, 1'b0, "dn_4b");
    push_idle(3, 4, "dn_idle");
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (i == 39) run = 1'b0;
    end
    drain(80);

    // Internal to external handoff and back
    div_start = 8'd4; sweep_en = 1'b0;
    @(negedge clk); #1;
    push_period(4, 4, 1'b0, "ho_per1"); push_period(4, 4, 1'b0, "ho_per2");
    push_n(1, 1'b0, 1'b0, 4, "ho_dead");
    push_n(5, 1'b1, 1'b0, 4, "ext_p");
    push_n(3, 1'b0, 1'b1, 4, "ext_n");
    push_n(3, 1'b0, 1'b0, 4, "ext_overlap");
    push_n(4, 1'b1, 1'b0, 4, "ext_p2");
    push_period(4, 4, 1'b0, "ext_exit");
    push_idle(3, 4, "ext_exit_idle");
    run = 1'b1;
    for (int i = 0; i < 34; i++) begin
      @(posedge clk); #2;
      case (i)
        9:  begin ext_lo_en = 1'b1; ext_lo_p = 1'b1; ext_lo_n = 1'b0; end
        19: begin ext_lo_p = 1'b0; ext_lo_n = 1'b1; end
        22: begin ext_lo_p = 1'b1; ext_lo_n = 1'b1; end
        25: begin ext_lo_p = 1'b1; ext_lo_n = 1'b0; end
        29: ext_lo_en = 1'b0;
        33: run = 1'b0;
        default: ;
      endcase
    end
    drain(60);

    // Async reset while lo_p is high, then restart
    div_start = 8'd4; sweep_en = 1'b0;
    @(negedge clk); #1;
    push_e(1'b0, 1'b0, 4, 1'b1, 1'b0, "rst_pre");
    run = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    check_val("pre_rst_lo_p", {15'd0, lo_p}, 16'h0001);
    rst = 1'b1;
    #1;
    check_val("async_rst", {3'd0, lo_p, lo_n, busy, wrap, 1'b0, cur_div}, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    push_period(4, 4, 1'b0, "rst_restart");
    push_idle(3, 4, "rst_idle");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (i == 3) run = 1'b0;
    end
    drain(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mixer_lo_sequencer.md
# mixer_lo_sequencer

Internal LO generator and sequencer for the Gilbert-cell mixer. Sits between the pad inputs and the mixer's `lo_p`/`lo_n` drive. Produces a non-overlapping differential LO from `clk` with a programmable divide ratio, and can sweep that ratio over a range with a programmable dwell. It also hands the mixer over glitch-free to a synchronized external LO.

## Interface

Parameters:
- `DIV_W`, 8: width of the half-period divide ratio.
- `DWELL_W`, 12: width of the dwell count, in LO periods.
- `DEAD_CYC`, 1: both-low dead-time cycles at the start of every half period; must be ≥1.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level; enable the internal LO.
- `sweep_en` in 1: level; step the divide ratio while running.
- `div_start` in DIV_W: first half-period ratio, in clk cycles.
- `div_stop` in DIV_W: last ratio of the sweep.
- `dwell` in DWELL_W: LO periods spent at each ratio, minus 1.
- `ext_lo_en` in 1: asynchronous; select the external LO.
- `ext_lo_p`, `ext_lo_n` in 1 each: asynchronous external LO.
- `lo_p`, `lo_n` out 1 each: registered mixer LO drive.
- `cur_div` out DIV_W: ratio currently in use.
- `busy` out 1: high in any state other than IDLE.
- `wrap` out 1: one-cycle pulse when the sweep wraps from `div_stop` back to `div_start`.

## Operation

- **Synchronization:** `ext_lo_en`, `ext_lo_p` and `ext_lo_n` each pass through a 2-flop synchronizer before use (suffix `_s`).
- **Ratio clamp:** the effective ratio is `max(div, DEAD_CYC+1)`. This clamp applies to `div_start`, `div_stop` and every sweep step.
- **States:**
  - IDLE: outputs 0/0.
  - INT: internal LO running.
  - HANDOFF: both outputs low for DEAD_CYC cycles.
  - EXT: synchronized external LO passed through.
- **INT waveform:**
  - The half-period counter runs 0..`cur_div`-1; the phase bit toggles when the counter reaches `cur_div`-1.
  - Counter values 0..DEAD_CYC-1: both outputs low. Remaining values: `lo_p`=1 in phase P, `lo_n`=1 in phase N.
  - The counter always restarts in phase P.
  - A period boundary is the wrap of the N half.
- **Transitions:**
  - IDLE→INT: on `run`=1 and `ext_lo_en_s`=0. Loads `cur_div`=`div_start`, dwell counter=0, counter=0, phase P.
  - IDLE→EXT: on `ext_lo_en_s`=1 (takes priority over `run`).
  - INT→IDLE on `run`=0, or INT→HANDOFF on `ext_lo_en_s`=1. Taken only at a period boundary; the current period always completes.
  - HANDOFF→EXT: after DEAD_CYC cycles of both-low.
  - EXT→INT or EXT→IDLE: on `ext_lo_en_s`=0, with next state chosen by `run`. Enters through one DEAD_CYC both-low window, then phase P.
- **EXT output:**
  - `lo_p`=`ext_lo_p_s` & ~`ext_lo_n_s`.
  - `lo_n`=`ext_lo_n_s` & ~`ext_lo_p_s`. Overlap is forced to 0/0.
- **Sweep:** active in INT when `sweep_en`=1.
  - The dwell counter increments at each period boundary.
  - When it equals `dwell`, it clears and `cur_div` steps toward `div_stop`: +1 if `div_stop`>`div_start`, −1 if smaller, no change if equal.
  - Reaching `div_stop` steps to `div_start` on the next step and pulses `wrap`.
  - `div_start` and `div_stop` are sampled at each step.
  - `sweep_en`=0: `cur_div` holds and the dwell counter clears.
- **Ratio updates:** `cur_div` changes only at a period boundary. No runt pulses.
- **Reset:** `lo_p`=`lo_n`=0, `cur_div`=0, `busy`=0, `wrap`=0, state IDLE, all synchronizers 0. Reset asserted mid-period forces 0/0 immediately.

## Timing

- Outputs are registered. `lo_*` reflects the state and counter after the clock edge.
- `run` sampled high at edge k: INT entered at k.
  - After edge k, counter value 0.
  - `lo_p` first rises after edge k+DEAD_CYC.
- External input to EXT output latency: 3 edges (2 synchronizer stages plus the output register).
- `ext_lo_en` assertion to EXT entry: 2 edges of synchronizer, then up to one LO period plus DEAD_CYC.
- Every transition between `lo_p`=1 and `lo_n`=1, in any state, has ≥DEAD_CYC cycles of 0/0.
- `wrap` is high for exactly the one cycle in which `cur_div` reloads.

## Structure

- Package `mixer_pkg`:
  - State enum `lo_state_t` (IDLE, INT, HANDOFF, EXT).
  - Default DIV_W, DWELL_W and DEAD_CYC constants.
- Sub-module `sync2`, a 2-flop synchronizer, instantiated three times.
- Top-level `lo_p`/`lo_n` replace the existing internal LO path when selected.

## Test plan

- **Fixed divide:** `div_start`=4, DEAD_CYC=1, `run`=1, `sweep_en`=0 → `lo_p` high 3 cycles, 0/0 for 1, `lo_n` high 3, 0/0 for 1; period 8; `cur_div`=4.
- **Up sweep:** `div_start`=3, `div_stop`=5, `dwell`=1 → `cur_div` follows 3,3 / 4,4 / 5,5 periods, then 3 with `wrap` pulsed once; no half period shorter than its ratio.
- **Down sweep and clamp:** `div_start`=5, `div_stop`=0 → `cur_div` descends to the clamp value DEAD_CYC+1=2, then wraps to 5.
- **Internal to external handoff:** assert `ext_lo_en` mid-P-half → P half and N half complete, DEAD_CYC cycles of 0/0, then `lo_p` tracks `ext_lo_p` delayed by 3 cycles. Driving `ext_lo_p`=`ext_lo_n`=1 → 0/0.
- **Run drop:** drop `run` mid-period → finishes at the period boundary, then IDLE, `busy`=0, outputs 0/0.
- **Async reset:** assert `rst` between clock edges while `lo_p`=1 → `lo_p`=0 immediately. Release with `run`=1 → restart from `div_start`, phase P after DEAD_CYC cycles.
